// File: rtl/period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of a slow asynchronous signal in clock_in cycles.
// Latency: results and valid_out 1 cycle after the synchronized rise (3 after the raw edge); no backpressure.
module period_meter #(
  parameter int unsigned            WIDTH  = 26,
  parameter logic [WIDTH-1:0]       MAXCNT = {WIDTH{1'b1}}
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             signal_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid_out,
  output logic             timeout_out,
  output logic             busy_out
);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcap;
  logic             s1, s2, s3;
  logic             rise, fall;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hcap        <= '0;
      period_out  <= '0;
      high_out    <= '0;
      valid_out   <= 1'b0;
      timeout_out <= 1'b0;
      busy_out    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (!enable) begin
        // Disabling abandons the partial period; the next rise is only a reference.
        state    <= IDLE;
        cnt      <= '0;
        busy_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state    <= MEASURE;
              cnt      <= WIDTH'(1);
              hcap     <= '0;
              busy_out <= 1'b1;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_out  <= cnt;
              high_out    <= hcap;
              cnt         <= WIDTH'(1);
              hcap        <= '0;
              timeout_out <= 1'b0;
              valid_out   <= 1'b1;
            end else if (cnt == MAXCNT) begin
              // Counter would saturate: give up and wait for a fresh reference edge.
              timeout_out <= 1'b1;
              state       <= IDLE;
              cnt         <= '0;
              busy_out    <= 1'b0;
            end else begin
              cnt <= cnt + WIDTH'(1);
              if (fall) hcap <= cnt;
            end
          end
          default: begin
            state    <= IDLE;
            cnt      <= '0;
            busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench: a default-width meter for long periods and an 8-bit meter for timeout boundaries.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_a, en_a, sig_b, en_b;
  logic [25:0] period_a, high_a;
  logic        valid_a, timeout_a, busy_a;
  logic [7:0]  period_b, high_b;
  logic        valid_b, timeout_b, busy_b;

  int          tests = 0;
  int          fails = 0;
  int          nvalid;
  logic [25:0] lastp, lasth;

  always #5 clk = ~clk;

  period_meter dut_a (
    .clock_in(clk), .reset(rst), .signal_in(sig_a), .enable(en_a),
    .period_out(period_a), .high_out(high_a), .valid_out(valid_a),
    .timeout_out(timeout_a), .busy_out(busy_a)
  );

  period_meter #(.WIDTH(8), .MAXCNT(8'd255)) dut_b (
    .clock_in(clk), .reset(rst), .signal_in(sig_b), .enable(en_b),
    .period_out(period_b), .high_out(high_b), .valid_out(valid_b),
    .timeout_out(timeout_b), .busy_out(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives nper periods of a square wave on one meter and records valid pulses seen.
  task automatic drive_wave(input bit sel, input int period, input int high, input int nper);
    nvalid = 0;
    for (int p = 0; p < nper; p++) begin
      for (int c = 0; c < period; c++) begin
        if (sel) sig_b = (c < high);
        else     sig_a = (c < high);
        tick();
        if (sel) begin
          if (valid_b) begin
            nvalid++;
            lastp = {18'd0, period_b};
            lasth = {18'd0, high_b};
          end
        end else begin
          if (valid_a) begin
            nvalid++;
            lastp = period_a;
            lasth = high_a;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sig_a = 1'b0; sig_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
    #1;
    tick(); tick();
    tests++; if (period_a !== 26'd0) begin fails++; $display("FAIL reset_period_a got %0d want 0", period_a); end
    tests++; if (high_a !== 26'd0) begin fails++; $display("FAIL reset_high_a got %0d want 0", high_a); end
    tests++; if ({valid_a, timeout_a, busy_a} !== 3'b000) begin fails++; $display("FAIL reset_flags_a got %b want 000", {valid_a, timeout_a, busy_a}); end
    tests++; if ({valid_b, timeout_b, busy_b, period_b, high_b} !== 19'd0) begin fails++; $display("FAIL reset_b got %h want 0", {valid_b, timeout_b, busy_b, period_b, high_b}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_square();
    int nv;
    nv = 0;
    sig_a = 1'b1;
    tick(); tick(); tick();
    tests++; if ({busy_a, valid_a} !== 2'b10) begin fails++; $display("FAIL square_first_rise busy,valid got %b want 10", {busy_a, valid_a}); end
    for (int c = 3; c < 1000; c++) begin
      sig_a = (c < 300);
      tick();
      if (valid_a) nv++;
    end
    tests++; if (nv !== 0) begin fails++; $display("FAIL square_reference_valid got %0d pulses want 0", nv); end
    drive_wave(1'b0, 1000, 300, 3);
    tests++; if (nvalid !== 3) begin fails++; $display("FAIL square_valid_count got %0d want 3", nvalid); end
    tests++; if (lastp !== 26'd1000) begin fails++; $display("FAIL square_period got %0d want 1000", lastp); end
    tests++; if (lasth !== 26'd300) begin fails++; $display("FAIL square_high got %0d want 300", lasth); end
  endtask

  task automatic test_enable();
    int nv;
    for (int c = 0; c < 500; c++) begin
      sig_a = (c < 300);
      tick();
    end
    en_a = 1'b0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid_a) nv++;
    end
    tests++; if (nv !== 0) begin fails++; $display("FAIL enable_off_valid got %0d pulses want 0", nv); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL enable_off_busy got %b want 0", busy_a); end
    tests++; if (period_a !== 26'd1000) begin fails++; $display("FAIL enable_off_hold got %0d want 1000", period_a); end
    en_a = 1'b1;
    for (int c = 0; c < 490; c++) tick();
    drive_wave(1'b0, 1000, 300, 1);
    tests++; if (nvalid !== 0) begin fails++; $display("FAIL enable_first_rise_valid got %0d want 0", nvalid); end
    tests++; if ({busy_a, period_a} !== {1'b1, 26'd1000}) begin fails++; $display("FAIL enable_rearm busy,period got %b,%0d want 1,1000", busy_a, period_a); end
    drive_wave(1'b0, 1000, 300, 2);
    tests++; if (nvalid !== 2 || lastp !== 26'd1000 || lasth !== 26'd300) begin fails++; $display("FAIL enable_resume got %0d pulses p=%0d h=%0d want 2 p=1000 h=300", nvalid, lastp, lasth); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 500; c++) begin
      sig_a = (c < 300);
      tick();
    end
    rst = 1'b1;
    #2;
    tests++; if ({period_a, high_a} !== 52'd0) begin fails++; $display("FAIL reset_mid_results got p=%0d h=%0d want 0 0", period_a, high_a); end
    tests++; if ({valid_a, timeout_a, busy_a} !== 3'b000) begin fails++; $display("FAIL reset_mid_flags got %b want 000", {valid_a, timeout_a, busy_a}); end
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 498; c++) tick();
    drive_wave(1'b0, 1000, 300, 1);
    tests++; if (nvalid !== 0) begin fails++; $display("FAIL reset_mid_reference got %0d pulses want 0", nvalid); end
    drive_wave(1'b0, 1000, 300, 1);
    tests++; if (nvalid !== 1 || lastp !== 26'd1000) begin fails++; $display("FAIL reset_mid_second got %0d pulses p=%0d want 1 p=1000", nvalid, lastp); end
  endtask

  task automatic test_pulse();
    drive_wave(1'b0, 50, 1, 4);
    tests++; if (nvalid !== 4) begin fails++; $display("FAIL pulse_count got %0d want 4", nvalid); end
    tests++; if (lastp !== 26'd50 || lasth !== 26'd1) begin fails++; $display("FAIL pulse_values got p=%0d h=%0d want p=50 h=1", lastp, lasth); end
    sig_a = 1'b1;
    tick();
    sig_a = 1'b0;
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL latency_cycle1 got %b want 0", valid_a); end
    tick();
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL latency_cycle2 got %b want 0", valid_a); end
    tick();
    tests++; if (valid_a !== 1'b1 || period_a !== 26'd50) begin fails++; $display("FAIL latency_cycle3 got v=%b p=%0d want v=1 p=50", valid_a, period_a); end
    tick();
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL latency_one_pulse got %b want 0", valid_a); end
  endtask

  task automatic test_timeout();
    drive_wave(1'b1, 100, 40, 2);
    tests++; if (nvalid !== 1 || lastp !== 26'd100 || lasth !== 26'd40) begin fails++; $display("FAIL timeout_setup got %0d pulses p=%0d h=%0d want 1 p=100 h=40", nvalid, lastp, lasth); end
    sig_b = 1'b1;
    tick(); tick(); tick();
    tests++; if (valid_b !== 1'b1 || period_b !== 8'd100) begin fails++; $display("FAIL timeout_ref_measure got v=%b p=%0d want v=1 p=100", valid_b, period_b); end
    for (int k = 4; k <= 257; k++) tick();
    tests++; if ({timeout_b, busy_b} !== 2'b01) begin fails++; $display("FAIL timeout_early got to,busy=%b want 01", {timeout_b, busy_b}); end
    tick();
    tests++; if ({timeout_b, busy_b, valid_b} !== 3'b100) begin fails++; $display("FAIL timeout_fire got to,busy,v=%b want 100", {timeout_b, busy_b, valid_b}); end
    tests++; if (period_b !== 8'd100 || high_b !== 8'd40) begin fails++; $display("FAIL timeout_hold got p=%0d h=%0d want p=100 h=40", period_b, high_b); end
    sig_b = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    drive_wave(1'b1, 100, 40, 1);
    tests++; if (nvalid !== 0 || timeout_b !== 1'b1) begin fails++; $display("FAIL timeout_rearm got %0d pulses to=%b want 0 to=1", nvalid, timeout_b); end
    drive_wave(1'b1, 100, 40, 1);
    tests++; if (nvalid !== 1 || timeout_b !== 1'b0 || lastp !== 26'd100) begin fails++; $display("FAIL timeout_clear got %0d pulses to=%b p=%0d want 1 to=0 p=100", nvalid, timeout_b, lastp); end
  endtask

  task automatic test_max_period();
    drive_wave(1'b1, 255, 10, 2);
    tests++; if (nvalid !== 2 || lastp !== 26'd255 || lasth !== 26'd10) begin fails++; $display("FAIL max_period got %0d pulses p=%0d h=%0d want 2 p=255 h=10", nvalid, lastp, lasth); end
    tests++; if (timeout_b !== 1'b0) begin fails++; $display("FAIL max_period_timeout got %b want 0", timeout_b); end
    drive_wave(1'b1, 256, 10, 2);
    tests++; if (nvalid !== 1 || lastp !== 26'd255) begin fails++; $display("FAIL over_max got %0d pulses p=%0d want 1 p=255", nvalid, lastp); end
    tests++; if ({timeout_b, busy_b} !== 2'b11) begin fails++; $display("FAIL over_max_flags got to,busy=%b want 11", {timeout_b, busy_b}); end
  endtask

  initial begin
    lastp = '0;
    lasth = '0;
    nvalid = 0;
    test_reset();
    test_square();
    test_enable();
    test_reset_mid();
    test_pulse();
    test_timeout();
    test_max_period();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 26, giving the counter and result width (holds 1 s at 50 MHz).
REQ-002 SHALL have parameter MAXCNT, default 2**WIDTH-1, giving the timeout count.
REQ-003 SHALL have port clock_in  input  1  system clock (50 MHz), all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port signal_in  input  1  asynchronous slow signal to measure (e.g. scaled clock).
REQ-006 SHALL have port enable  input  1  measurement enable, level-sensitive.
REQ-007 SHALL have port period_out  output  WIDTH  last measured rise-to-rise period in clock_in cycles.
REQ-008 SHALL have port high_out  output  WIDTH  last measured rise-to-fall high time in clock_in cycles.
REQ-009 SHALL have port valid_out  output  1  one-cycle pulse when period_out/high_out update.
REQ-010 SHALL have port timeout_out  output  1  sticky flag: no rising edge within MAXCNT cycles.
REQ-011 SHALL have port busy_out  output  1  high while in state MEASURE.

Function
REQ-012 SHALL pass signal_in through a 2-flop synchronizer, then a third flop for edge detection; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-013 SHALL implement states IDLE (wait for reference rise) and MEASURE (counting).
REQ-014 IDLE -> MEASURE SHALL occur on a rise while enable=1; that cycle loads cnt <= 1, no valid_out.
REQ-015 In MEASURE, cnt SHALL increment by 1 each cycle without rise, saturating at MAXCNT.
REQ-016 In MEASURE, a fall SHALL capture hcap <= cnt (cycles from rise to fall).
REQ-017 In MEASURE, a rise SHALL load period_out <= cnt, high_out <= hcap, cnt <= 1, clear timeout_out, assert valid_out for the next cycle only; state remains MEASURE.
REQ-018 Latency SHALL be: valid_out and new results visible exactly 1 cycle after the cycle in which the rise is detected (3 cycles after the signal_in rising edge at synchronizer input).
REQ-019 When cnt = MAXCNT and no rise in that cycle, SHALL set timeout_out <= 1, go to IDLE, leave period_out/high_out unchanged, no valid_out.
REQ-020 Rise in the same cycle as cnt = MAXCNT SHALL be treated as a valid measurement (period_out = MAXCNT), no timeout.
REQ-021 hcap SHALL be cleared to 0 on each rise; a period without a detected fall SHALL report high_out = 0.
REQ-022 enable=0 SHALL force state IDLE and cnt <= 0 next cycle, hold period_out/high_out/timeout_out, suppress valid_out; synchronizer keeps running.
REQ-023 Rise and enable deassertion in the same cycle SHALL give enable priority (no update, go IDLE).
REQ-024 All arithmetic SHALL be unsigned WIDTH-bit; cnt SHALL never wrap.
REQ-025 busy_out SHALL equal (state == MEASURE), registered with the state.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, cnt=0, hcap=0, synchronizer flops=0, period_out=0, high_out=0, valid_out=0, timeout_out=0, busy_out=0.
REQ-027 A rise already high in signal_in at reset release SHALL be detected as a rise (s3=0) only after propagating through the synchronizer.
REQ-028 Reset mid-measurement SHALL discard the partial count; first rise after release is a reference edge only.

Verification
REQ-029 Square wave period 1000, high 300 cycles, enable=1 -> first rise: busy_out=1, no valid; each later rise: valid_out one cycle, period_out=1000, high_out=300.
REQ-030 WIDTH=8, MAXCNT=255, one rise then signal stuck -> timeout_out=1 at cycle 255 after reference, busy_out=0, outputs unchanged; next two rises -> valid, timeout_out=0.
REQ-031 WIDTH=8, rise-to-rise exactly 255 cycles -> valid_out, period_out=255, timeout_out=0.
REQ-032 Reset asserted 500 cycles into a 1000-cycle period -> all outputs 0 immediately; after release, first rise gives no valid, second gives period_out=1000.
REQ-033 enable dropped mid-period for 10 cycles, then raised -> no valid until two rises after re-enable; prior period_out held throughout.
REQ-034 Signal high for 1 cycle every 50 cycles -> period_out=50, high_out=1.
